// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: one-cycle grant, alternating tie-break, combinational routing.
// Optional bus-hang abort is compiled in when WB_ARB_TIMEOUT_EN is defined.
module wb_arbiter_2m #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_m0_cyc,
  input  logic        i_m0_stb,
  input  logic        i_m0_we,
  input  logic [29:0] i_m0_addr,
  input  logic [31:0] i_m0_data,
  input  logic [3:0]  i_m0_sel,
  input  logic        i_m1_cyc,
  input  logic        i_m1_stb,
  input  logic        i_m1_we,
  input  logic [29:0] i_m1_addr,
  input  logic [31:0] i_m1_data,
  input  logic [3:0]  i_m1_sel,
  output logic        o_m0_stall,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  output logic [31:0] o_m0_data,
  output logic        o_m1_stall,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic [31:0] o_m1_data,
  output logic        o_s_cyc,
  output logic        o_s_stb,
  output logic        o_s_we,
  output logic [29:0] o_s_addr,
  output logic [31:0] o_s_data,
  output logic [3:0]  o_s_sel,
  input  logic        i_s_stall,
  input  logic        i_s_ack,
  input  logic        i_s_err,
  input  logic [31:0] i_s_data,
  output logic [1:0]  o_grant
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_arbiter_2m: TIMEOUT_CYCLES must be within 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
`ifdef WB_ARB_TIMEOUT_EN
    , ABORT = 2'd3
`endif
  } state_t;

  state_t state_reg, state_next;
  logic   last_owner_reg, last_owner_next;

  logic [1:0]  m_cyc, m_stb, m_we;
  logic [29:0] m_addr [2];
  logic [31:0] m_data [2];
  logic [3:0]  m_sel  [2];

  assign m_cyc     = {i_m1_cyc, i_m0_cyc};
  assign m_stb     = {i_m1_stb, i_m0_stb};
  assign m_we      = {i_m1_we,  i_m0_we};
  assign m_addr[0] = i_m0_addr;
  assign m_addr[1] = i_m1_addr;
  assign m_data[0] = i_m0_data;
  assign m_data[1] = i_m1_data;
  assign m_sel[0]  = i_m0_sel;
  assign m_sel[1]  = i_m1_sel;

  logic owner_valid;
  logic owner;
  logic tmo_hit;

  assign owner_valid = (state_reg == GNT0) || (state_reg == GNT1);
  assign owner       = (state_reg == GNT1);

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt_reg, tmo_cnt_next;
  logic        abort_owner_reg, abort_owner_next;
  logic        counting;

  // A strobe left unanswered by the slave is what counts towards the abort.
  assign counting = owner_valid && m_stb[owner] && !i_s_ack && !i_s_err;
  assign tmo_hit  = counting && (tmo_cnt_reg == TMO_LAST);

  always_comb begin
    tmo_cnt_next = tmo_cnt_reg;
    if ((state_next != state_reg) || i_s_ack || i_s_err) begin
      tmo_cnt_next = '0;
    end else if (counting) begin
      tmo_cnt_next = tmo_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tmo_cnt_reg     <= '0;
      abort_owner_reg <= 1'b0;
    end else begin
      tmo_cnt_reg     <= tmo_cnt_next;
      abort_owner_reg <= abort_owner_next;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg      <= IDLE;
      last_owner_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      last_owner_reg <= last_owner_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next      = state_reg;
    last_owner_next = last_owner_reg;
`ifdef WB_ARB_TIMEOUT_EN
    abort_owner_next = abort_owner_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (m_cyc == 2'b11) begin
          state_next = last_owner_reg ? GNT0 : GNT1;
        end else if (m_cyc[0]) begin
          state_next = GNT0;
        end else if (m_cyc[1]) begin
          state_next = GNT1;
        end
      end
      GNT0, GNT1: begin
`ifdef WB_ARB_TIMEOUT_EN
        if (tmo_hit) begin
          state_next       = ABORT;
          abort_owner_next = owner;
        end else
`endif
        if (!m_cyc[owner]) begin
          // Hand over directly when the other master is already waiting.
          last_owner_next = owner;
          if (m_cyc[~owner]) begin
            state_next = owner ? GNT0 : GNT1;
          end else begin
            state_next = IDLE;
          end
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      ABORT: begin
        if (!m_cyc[abort_owner_reg]) begin
          state_next      = IDLE;
          last_owner_next = abort_owner_reg;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Output logic: slave side follows the owner, quiet otherwise
  always_comb begin
    o_s_cyc  = 1'b0;
    o_s_stb  = 1'b0;
    o_s_we   = 1'b0;
    o_s_addr = '0;
    o_s_data = '0;
    o_s_sel  = '0;
    if (owner_valid) begin
      o_s_cyc  = m_cyc[owner];
      o_s_stb  = m_stb[owner];
      o_s_we   = m_we[owner];
      o_s_addr = m_addr[owner];
      o_s_data = m_data[owner];
      o_s_sel  = m_sel[owner];
    end
  end

  assign o_grant = {state_reg == GNT1, state_reg == GNT0};

  logic [1:0]  rsp_stall, rsp_ack, rsp_err;
  logic [31:0] rsp_data [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    logic mine;
    assign mine          = owner_valid && (owner == 1'(gi));
    assign rsp_stall[gi] = mine ? i_s_stall : 1'b1;
    assign rsp_ack[gi]   = mine ? i_s_ack : 1'b0;
    assign rsp_err[gi]   = mine ? (i_s_err | tmo_hit) : 1'b0;
    assign rsp_data[gi]  = mine ? i_s_data : 32'd0;
  end

  assign o_m0_stall = rsp_stall[0];
  assign o_m0_ack   = rsp_ack[0];
  assign o_m0_err   = rsp_err[0];
  assign o_m0_data  = rsp_data[0];
  assign o_m1_stall = rsp_stall[1];
  assign o_m1_ack   = rsp_ack[1];
  assign o_m1_err   = rsp_err[1];
  assign o_m1_data  = rsp_data[1];

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: directed scenarios plus a per-cycle ownership model.
module tb_wb_arbiter_2m;
  localparam int T = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_m0_cyc, i_m0_stb, i_m0_we;
  logic [29:0] i_m0_addr;
  logic [31:0] i_m0_data;
  logic [3:0]  i_m0_sel;
  logic        i_m1_cyc, i_m1_stb, i_m1_we;
  logic [29:0] i_m1_addr;
  logic [31:0] i_m1_data;
  logic [3:0]  i_m1_sel;
  logic        o_m0_stall, o_m0_ack, o_m0_err;
  logic [31:0] o_m0_data;
  logic        o_m1_stall, o_m1_ack, o_m1_err;
  logic [31:0] o_m1_data;
  logic        o_s_cyc, o_s_stb, o_s_we;
  logic [29:0] o_s_addr;
  logic [31:0] o_s_data;
  logic [3:0]  o_s_sel;
  logic        i_s_stall, i_s_ack, i_s_err;
  logic [31:0] i_s_data;
  logic [1:0]  o_grant;

  always #5 i_clk = ~i_clk;

  wb_arbiter_2m #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we),
    .i_m0_addr(i_m0_addr), .i_m0_data(i_m0_data), .i_m0_sel(i_m0_sel),
    .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we),
    .i_m1_addr(i_m1_addr), .i_m1_data(i_m1_data), .i_m1_sel(i_m1_sel),
    .o_m0_stall(o_m0_stall), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err), .o_m0_data(o_m0_data),
    .o_m1_stall(o_m1_stall), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err), .o_m1_data(o_m1_data),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
    .o_s_addr(o_s_addr), .o_s_data(o_s_data), .o_s_sel(o_s_sel),
    .i_s_stall(i_s_stall), .i_s_ack(i_s_ack), .i_s_err(i_s_err), .i_s_data(i_s_data),
    .o_grant(o_grant)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  // Model: who owns the bus (-1 = nobody), who won last, pending abort, strobes waited.
  int own      = -1;
  bit last_m   = 1'b1;
  bit aborting = 1'b0;
  int abort_m  = 0;
  int waited   = 0;
  bit model_ok = 1'b0;

  function automatic bit mcyc(input int n);
    return (n == 0) ? i_m0_cyc : i_m1_cyc;
  endfunction

  function automatic bit mstb(input int n);
    return (n == 0) ? i_m0_stb : i_m1_stb;
  endfunction

  function automatic bit tmo_now();
    if (!TMO_EN || own < 0) return 1'b0;
    return mstb(own) && !i_s_ack && !i_s_err && (waited == T - 1);
  endfunction

  always @(posedge i_clk) begin
    if (!i_rst_n) begin
      own <= -1; last_m <= 1'b1; aborting <= 1'b0; waited <= 0; model_ok <= 1'b1;
    end else if (model_ok) begin
      if (aborting) begin
        if (!mcyc(abort_m)) begin
          aborting <= 1'b0;
          last_m   <= (abort_m == 1);
        end
      end else if (own < 0) begin
        waited <= 0;
        if (i_m0_cyc && i_m1_cyc) own <= last_m ? 0 : 1;
        else if (i_m0_cyc)        own <= 0;
        else if (i_m1_cyc)        own <= 1;
      end else if (tmo_now()) begin
        aborting <= 1'b1; abort_m <= own; own <= -1; waited <= 0;
      end else if (!mcyc(own)) begin
        last_m <= (own == 1);
        own    <= mcyc(1 - own) ? 1 - own : -1;
        waited <= 0;
      end else if (i_s_ack || i_s_err) begin
        waited <= 0;
      end else if (mstb(own)) begin
        waited <= waited + 1;
      end
    end
  end

  always @(negedge i_clk) begin : cmp
    logic [1:0]  eg;
    logic [68:0] es;
    logic [34:0] e0, e1;
    bit          t;
    if (model_ok) begin
      t  = tmo_now();
      eg = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
      es = '0;
      if (own == 0) es = {i_m0_cyc, i_m0_stb, i_m0_we, i_m0_addr, i_m0_data, i_m0_sel};
      if (own == 1) es = {i_m1_cyc, i_m1_stb, i_m1_we, i_m1_addr, i_m1_data, i_m1_sel};
      e0 = (own == 0) ? {i_s_stall, i_s_ack, i_s_err | t, i_s_data} : {1'b1, 1'b0, 1'b0, 32'd0};
      e1 = (own == 1) ? {i_s_stall, i_s_ack, i_s_err | t, i_s_data} : {1'b1, 1'b0, 1'b0, 32'd0};
      check("model_grant", 128'(o_grant), 128'(eg));
      check("model_slave", 128'({o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel}), 128'(es));
      check("model_m0", 128'({o_m0_stall, o_m0_ack, o_m0_err, o_m0_data}), 128'(e0));
      check("model_m1", 128'({o_m1_stall, o_m1_ack, o_m1_err, o_m1_data}), 128'(e1));
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_m0_cyc = 1'b1; i_m0_stb = 1'b0; i_m0_we = 1'b0; i_m0_addr = '0; i_m0_data = '0; i_m0_sel = '0;
    i_m1_cyc = 1'b0; i_m1_stb = 1'b0; i_m1_we = 1'b0; i_m1_addr = '0; i_m1_data = '0; i_m1_sel = '0;
    i_s_stall = 1'b0; i_s_ack = 1'b0; i_s_err = 1'b0; i_s_data = '0;

    // Reset held two cycles while m0 requests
    @(negedge i_clk);
    check("rst_grant", 128'(o_grant), 128'(2'b00));
    check("rst_m0_stall", 128'(o_m0_stall), 128'(1'b1));
    check("rst_s_cyc", 128'(o_s_cyc), 128'(1'b0));
    tick();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("release_idle", 128'(o_grant), 128'(2'b00));
    tick();
    @(negedge i_clk);
    check("release_grant", 128'(o_grant), 128'(2'b01));
    check("grant_latency_cyc", 128'(o_s_cyc), 128'(1'b1));
    $display("txn reset/release: grant=%b", o_grant);
    tick();
    i_m0_cyc = 1'b0;
    tick();

    // Tie after a fresh reset: m0 wins, then hands straight to m1
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1; i_m0_cyc = 1'b1; i_m1_cyc = 1'b1;
    tick();
    @(negedge i_clk);
    check("tie_m0_wins", 128'(o_grant), 128'(2'b01));
    tick();
    i_m0_cyc = 1'b0;
    tick();
    @(negedge i_clk);
    check("handover_no_idle", 128'(o_grant), 128'(2'b10));
    $display("txn tie/handover: grant=%b", o_grant);

    // Routed write from m1
    tick();
    i_m1_stb = 1'b1; i_m1_we = 1'b1; i_m1_addr = 30'd3; i_m1_data = 32'h1234; i_m1_sel = 4'hf;
    i_s_ack = 1'b1;
    @(negedge i_clk);
    check("wr_m1_ack", 128'(o_m1_ack), 128'(1'b1));
    check("wr_m0_ack", 128'(o_m0_ack), 128'(1'b0));
    check("wr_s_addr", 128'(o_s_addr), 128'(30'd3));
    check("wr_s_data", 128'(o_s_data), 128'(32'h1234));
    check("wr_s_we", 128'(o_s_we), 128'(1'b1));
    $display("txn write m1: addr=%0h data=%0h ack=%b", o_s_addr, o_s_data, o_m1_ack);
    tick();
    i_m1_stb = 1'b0; i_m1_we = 1'b0; i_m1_addr = '0; i_m1_data = '0; i_m1_sel = '0;
    i_s_ack = 1'b0; i_m1_cyc = 1'b0;
    tick();

    // Slave response while idle is dropped
    i_s_ack = 1'b1; i_s_err = 1'b1; i_s_data = 32'hdead_beef;
    @(negedge i_clk);
    check("idle_m0_ack", 128'(o_m0_ack), 128'(1'b0));
    check("idle_m1_ack", 128'(o_m1_ack), 128'(1'b0));
    check("idle_m0_err", 128'(o_m0_err), 128'(1'b0));
    check("idle_m0_data", 128'(o_m0_data), 128'(32'd0));
    $display("txn idle ack discard: m0_ack=%b m1_ack=%b", o_m0_ack, o_m1_ack);

    // Routed read to m0, with m1 waiting
    tick();
    i_s_ack = 1'b0; i_s_err = 1'b0; i_s_data = '0;
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_addr = 30'd5; i_m0_sel = 4'hf;
    tick();
    i_s_ack = 1'b1; i_s_data = 32'h0000_0005; i_m1_cyc = 1'b1;
    @(negedge i_clk);
    check("rd_m0_data", 128'(o_m0_data), 128'(32'h5));
    check("rd_m0_ack", 128'(o_m0_ack), 128'(1'b1));
    check("rd_m1_data", 128'(o_m1_data), 128'(32'd0));
    check("rd_m1_stall", 128'(o_m1_stall), 128'(1'b1));
    $display("txn read m0: data=%0h ack=%b", o_m0_data, o_m0_ack);
    tick();
    i_s_ack = 1'b0; i_s_data = '0; i_m0_stb = 1'b0; i_s_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("hold_m0", 128'(o_grant), 128'(2'b01));
      tick();
    end
    @(negedge i_clk);
    check("stall_fwd", 128'(o_m0_stall), 128'(1'b1));
    tick();
    i_s_stall = 1'b0;
    @(negedge i_clk);
    check("stall_fwd_low", 128'(o_m0_stall), 128'(1'b0));
    tick();
    i_m0_cyc = 1'b0;
    tick();
    @(negedge i_clk);
    check("hold_then_m1", 128'(o_grant), 128'(2'b10));
    tick();
    i_m1_cyc = 1'b0;
    tick();

    // Slave never acks a strobing m0
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_addr = 30'd7;
    tick();
    for (int i = 1; i <= 4; i++) begin
      @(negedge i_clk);
      check("tmo_err", 128'(o_m0_err), 128'((i == 4) && TMO_EN));
      check("tmo_s_cyc", 128'(o_s_cyc), 128'(1'b1));
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      check("abort_s_cyc", 128'(o_s_cyc), 128'(!TMO_EN));
      check("abort_grant", 128'(o_grant), TMO_EN ? 128'(2'b00) : 128'(2'b01));
      check("abort_m0_stall", 128'(o_m0_stall), 128'(TMO_EN));
      check("abort_m0_err", 128'(o_m0_err), 128'(1'b0));
      tick();
    end
    i_m0_cyc = 1'b0; i_m0_stb = 1'b0; i_m0_addr = '0;
    tick();
    @(negedge i_clk);
    check("abort_release", 128'(o_grant), 128'(2'b00));
    $display("txn unanswered strobe: timeout_en=%0d grant=%b", TMO_EN, o_grant);

    // Reset in the middle of an m1 transfer
    tick();
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1; i_m1_addr = 30'd9;
    tick();
    i_rst_n = 1'b0;
    @(negedge i_clk);
    check("midrst_before", 128'(o_s_cyc), 128'(1'b1));
    tick();
    @(negedge i_clk);
    check("midrst_s_cyc", 128'(o_s_cyc), 128'(1'b0));
    check("midrst_grant", 128'(o_grant), 128'(2'b00));
    check("midrst_m1_stall", 128'(o_m1_stall), 128'(1'b1));
    $display("txn reset mid-transfer: s_cyc=%b", o_s_cyc);
    tick();
    i_rst_n = 1'b1; i_m1_cyc = 1'b0; i_m1_stb = 1'b0; i_m1_addr = '0;
    tick();
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
